// File: rtl/bcd_time_counter.sv
// mm:ss BCD up/down timer with a clk prescaler tick, manual field presets in setup mode,
// and a terminal-count flag that is sticky (stop mode) or a one-cycle pulse (wrap mode).
module bcd_time_counter #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned MAX_MINUTES = 59,
  parameter int unsigned WRAP        = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       forward,
  input  logic       incrementSeconds,
  input  logic       incrementMinutes,
  output logic [3:0] secondsDecimals,
  output logic [3:0] secondsUnits,
  output logic [3:0] minutesDecimals,
  output logic [3:0] minutesUnits,
  output logic       finish,
  output logic       tick
);

  localparam int unsigned PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0]  MAX_MM = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10)};

  // Fields are kept as {tens, units} BCD bytes.
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          finish_q, finish_d;
  logic          tick_q, tick_d;

  function automatic logic [7:0] sec_up(input logic [7:0] s);
    if (s == 8'h59)        return 8'h00;
    else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    else                   return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] sec_dn(input logic [7:0] s);
    if (s == 8'h00)        return 8'h59;
    else if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
    else                   return {s[7:4], s[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] min_up(input logic [7:0] m);
    if (m == MAX_MM)       return 8'h00;
    else if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    else                   return {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] min_dn(input logic [7:0] m);
    if (m == 8'h00)        return MAX_MM;
    else if (m[3:0] == 4'd0) return {m[7:4] - 4'd1, 4'd9};
    else                   return {m[7:4], m[3:0] - 4'd1};
  endfunction

  logic       at_term_c;
  logic       roll_c;
  logic [7:0] step_sec_c;
  logic [7:0] step_min_c;

  // Next-state: prescaler, tick-driven count step, setup-mode presets.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    finish_d = (WRAP != 0) ? 1'b0 : finish_q;

    at_term_c  = forward ? ((min_q == MAX_MM) && (sec_q == 8'h59))
                         : ((min_q == 8'h00) && (sec_q == 8'h00));
    roll_c     = forward ? (sec_q == 8'h59) : (sec_q == 8'h00);
    step_sec_c = forward ? sec_up(sec_q) : sec_dn(sec_q);
    step_min_c = roll_c ? (forward ? min_up(min_q) : min_dn(min_q)) : min_q;

    if (enable) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (WRAP != 0) begin
          sec_d    = step_sec_c;
          min_d    = step_min_c;
          finish_d = at_term_c;
        end else if (!finish_q) begin
          // Starting at terminal only raises the flag; otherwise step and flag on arrival.
          if (at_term_c) begin
            finish_d = 1'b1;
          end else begin
            sec_d    = step_sec_c;
            min_d    = step_min_c;
            finish_d = forward ? ((step_min_c == MAX_MM) && (step_sec_c == 8'h59))
                               : ((step_min_c == 8'h00) && (step_sec_c == 8'h00));
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      if (incrementSeconds) sec_d = sec_up(sec_q);
      if (incrementMinutes) min_d = min_up(min_q);
      if (incrementSeconds || incrementMinutes) finish_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q    <= '0;
      min_q    <= '0;
      presc_q  <= '0;
      finish_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      sec_q    <= sec_d;
      min_q    <= min_d;
      presc_q  <= presc_d;
      finish_q <= finish_d;
      tick_q   <= tick_d;
    end
  end

  assign secondsDecimals = sec_q[7:4];
  assign secondsUnits    = sec_q[3:0];
  assign minutesDecimals = min_q[7:4];
  assign minutesUnits    = min_q[3:0];
  assign finish          = finish_q;
  assign tick            = tick_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: a stop-mode and a wrap-mode instance share stimulus and are
// compared every cycle against an integer-seconds reference model, plus directed checkpoints.
module tb_bcd_time_counter;

  localparam int unsigned TD   = 4;
  localparam int unsigned MAXM = 2;
  localparam int          TOT  = (MAXM + 1) * 60;

  logic clk = 1'b0;
  logic reset, enable, forward, incS, incM;
  logic [3:0] sd [2];
  logic [3:0] su [2];
  logic [3:0] md [2];
  logic [3:0] mu [2];
  logic       fin [2];
  logic       tk [2];

  int checks = 0;
  int errors = 0;

  // Reference state: total seconds, prescaler, finish, tick per instance.
  int T [2];
  int P [2];
  bit F [2];
  bit K [2];

  always #5 clk = ~clk;

  bcd_time_counter #(.TICK_DIV(TD), .MAX_MINUTES(MAXM), .WRAP(0)) u_stop (
    .clk(clk), .reset(reset), .enable(enable), .forward(forward),
    .incrementSeconds(incS), .incrementMinutes(incM),
    .secondsDecimals(sd[0]), .secondsUnits(su[0]),
    .minutesDecimals(md[0]), .minutesUnits(mu[0]),
    .finish(fin[0]), .tick(tk[0])
  );

  bcd_time_counter #(.TICK_DIV(TD), .MAX_MINUTES(MAXM), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .forward(forward),
    .incrementSeconds(incS), .incrementMinutes(incM),
    .secondsDecimals(sd[1]), .secondsUnits(su[1]),
    .minutesDecimals(md[1]), .minutesUnits(mu[1]),
    .finish(fin[1]), .tick(tk[1])
  );

  function automatic logic [15:0] dig(input int i);
    return {md[i], mu[i], sd[i], su[i]};
  endfunction

  function automatic logic [15:0] exp_dig(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_step();
    int mm, ss;
    bit term;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        T[i] = 0; P[i] = 0; F[i] = 0; K[i] = 0;
      end else begin
        K[i] = 0;
        if (i == 1) F[i] = 0;
        if (enable) begin
          if (P[i] == TD - 1) begin
            P[i] = 0;
            K[i] = 1;
            term = forward ? (T[i] == TOT - 1) : (T[i] == 0);
            if (i == 1) begin
              T[i] = (T[i] + (forward ? 1 : TOT - 1)) % TOT;
              F[i] = term;
            end else if (!F[i]) begin
              if (term) F[i] = 1;
              else begin
                T[i] = forward ? T[i] + 1 : T[i] - 1;
                F[i] = forward ? (T[i] == TOT - 1) : (T[i] == 0);
              end
            end
          end else begin
            P[i] = P[i] + 1;
          end
        end else begin
          mm = T[i] / 60;
          ss = T[i] % 60;
          if (incS) ss = (ss + 1) % 60;
          if (incM) mm = (mm + 1) % (MAXM + 1);
          if (incS || incM) F[i] = 0;
          T[i] = mm * 60 + ss;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("model_digits", i, dig(i), exp_dig(T[i]));
        chk("model_finish", i, 16'(fin[i]), 16'(F[i]));
        chk("model_tick", i, 16'(tk[i]), 16'(K[i]));
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; forward = 1'b1; incS = 1'b0; incM = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_digits", 0, dig(0), 16'h0000);
    chk("rst_finish", 0, 16'(fin[0]), 16'h0);
    chk("rst_tick", 0, 16'(tk[0]), 16'h0);
    chk("rst_digits", 1, dig(1), 16'h0000);

    // Manual presets: seconds wrap without carry, minutes wrap at MAX
    reset = 1'b0;
    incS = 1'b1; cyc(61); incS = 1'b0;
    chk("inc_sec61", 0, dig(0), 16'h0001);
    incM = 1'b1; cyc(3); incM = 1'b0;
    chk("inc_min3", 0, dig(0), 16'h0001);
    chk("inc_min3", 1, dig(1), 16'h0001);

    // Count down from 01:00 to terminal, then hold (stop) / wrap (wrap)
    reset = 1'b1; cyc(1); reset = 1'b0;
    incM = 1'b1; cyc(1); incM = 1'b0;
    chk("preset_0100", 0, dig(0), 16'h0100);
    forward = 1'b0; enable = 1'b1;
    cyc(4);
    chk("down_first", 0, dig(0), 16'h0059);
    chk("down_first_tick", 0, 16'(tk[0]), 16'h1);
    cyc(236);
    chk("down_term", 0, dig(0), 16'h0000);
    chk("down_term_fin", 0, 16'(fin[0]), 16'h1);
    chk("down_reach_fin", 1, 16'(fin[1]), 16'h0);
    cyc(4);
    chk("down_hold", 0, dig(0), 16'h0000);
    chk("down_hold_fin", 0, 16'(fin[0]), 16'h1);
    chk("down_wrap", 1, dig(1), 16'h0259);
    chk("down_wrap_fin", 1, 16'(fin[1]), 16'h1);
    cyc(1);
    chk("down_wrap_pulse", 1, 16'(fin[1]), 16'h0);

    // Count up into terminal, ignored increment while running, clear by preset
    enable = 1'b0; reset = 1'b1; cyc(1); reset = 1'b0;
    incM = 1'b1; cyc(2); incM = 1'b0;
    incS = 1'b1; cyc(58); incS = 1'b0;
    chk("preset_0258", 0, dig(0), 16'h0258);
    forward = 1'b1; enable = 1'b1;
    cyc(4);
    chk("up_term", 0, dig(0), 16'h0259);
    chk("up_term_fin", 0, 16'(fin[0]), 16'h1);
    chk("up_reach_fin", 1, 16'(fin[1]), 16'h0);
    incS = 1'b1; cyc(1); incS = 1'b0;
    chk("inc_ignored", 0, dig(0), 16'h0259);
    cyc(3);
    chk("up_hold", 0, dig(0), 16'h0259);
    chk("up_wrap", 1, dig(1), 16'h0000);
    chk("up_wrap_fin", 1, 16'(fin[1]), 16'h1);
    enable = 1'b0; incS = 1'b1; cyc(1); incS = 1'b0;
    chk("clr_digits", 0, dig(0), 16'h0200);
    chk("clr_finish", 0, 16'(fin[0]), 16'h0);
    chk("clr_digits", 1, dig(1), 16'h0001);

    // Reset mid-count drops any pending tick
    reset = 1'b1; cyc(1); reset = 1'b0;
    incM = 1'b1; cyc(1); incM = 1'b0;
    incS = 1'b1; cyc(30); incS = 1'b0;
    chk("preset_0130", 0, dig(0), 16'h0130);
    enable = 1'b1; forward = 1'b1;
    cyc(2);
    reset = 1'b1; cyc(1);
    chk("midrst_digits", 0, dig(0), 16'h0000);
    chk("midrst_tick", 0, 16'(tk[0]), 16'h0);
    reset = 1'b0;
    cyc(3);
    chk("post_rst_notick", 0, 16'(tk[0]), 16'h0);
    cyc(1);
    chk("post_rst_tick", 0, 16'(tk[0]), 16'h1);
    chk("post_rst_digits", 0, dig(0), 16'h0001);

    // Randomized traffic against the model
    for (int n = 0; n < 6000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0)  enable = ~enable;
      if ($urandom_range(0, 511) == 0) forward = ~forward;
      incS = ($urandom_range(0, 3) == 0);
      incM = ($urandom_range(0, 7) == 0);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
